// File: rtl/nn_avalon_if.sv
// Avalon-MM bus bundle between the NN host master and the accelerator slave.
// Single-word transfers only: burstcount is always 1, beginbursttransfer 0.
interface nn_avalon_if;
    logic [12:0] address;
    logic        write;
    logic        read;
    logic [31:0] writedata;
    logic [9:0]  burstcount;
    logic        beginbursttransfer;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;

    modport master (
        output address, write, read, writedata, burstcount, beginbursttransfer,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, write, read, writedata, burstcount, beginbursttransfer,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/nn_avalon_host.sv
// nn_avalon_host: host-side Avalon-MM master for the NN accelerator.
// Pulses reset through the control register, streams pixel and weight words
// from a local source memory (single-word writes), starts the accelerator,
// polls status until done, reads the result registers and reports them.
// Optional feature macro: NN_HOST_POLL_TIMEOUT_EN bounds the status polling
// to TIMEOUT_POLLS reads and raises error on expiry.
module nn_avalon_host #(
    parameter int N_PIX_WORDS   = 98,
    parameter int N_WEIGHTS     = 3920,
    parameter int N_RESULTS     = 10,
    parameter int WGT_BASE      = 196,
    parameter int RES_BASE      = 4116,
    parameter int CTRL_ADDR     = 4126,
    parameter int STAT_ADDR     = 4127,
    parameter int TIMEOUT_POLLS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    output logic [11:0] src_addr,
    output logic        src_rd,
    input  logic [31:0] src_rdata,
    nn_avalon_if.master av,
    output logic [16:0] result_data,
    output logic [3:0]  result_idx,
    output logic        result_valid,
    output logic        overflow,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [3:0] {
        IDLE, CLR_SET, CLR_REL,
        PIX_FETCH, PIX_LOAD, PIX_WR,
        WGT_FETCH, WGT_LOAD, WGT_WR,
        START, POLL_RD, POLL_WAIT, RES_RD, RES_WAIT,
        STOP, FIN
    } state_t;

    localparam logic [11:0] PIX_LAST = 12'(N_PIX_WORDS - 1);
    localparam logic [11:0] WGT_LAST = 12'(N_WEIGHTS - 1);
    localparam logic [11:0] RES_LAST = 12'(N_RESULTS - 1);
    localparam logic [11:0] WGT_SRC  = 12'(N_PIX_WORDS);
    localparam logic [12:0] WGT_A    = 13'(WGT_BASE);
    localparam logic [12:0] RES_A    = 13'(RES_BASE);
    localparam logic [12:0] CTRL_A   = 13'(CTRL_ADDR);
    localparam logic [12:0] STAT_A   = 13'(STAT_ADDR);

    state_t      state, state_nx;
    logic [11:0] cnt;
    logic [31:0] wdata_q;
    logic        stat_done;
    logic        poll_expired;

    // A bus transfer completes (write) or is accepted (read) when not stalled.
    logic xfer_ok;
    assign xfer_ok   = !av.waitrequest;
    assign stat_done = av.readdata[0];

`ifdef NN_HOST_POLL_TIMEOUT_EN
    localparam int PW = $clog2(TIMEOUT_POLLS + 1);
    logic [PW-1:0] poll_cnt;
    assign poll_expired = (poll_cnt >= PW'(TIMEOUT_POLLS));

    // Count accepted status reads and flag a timeout; both clear on go.
    always_ff @(posedge clk) begin
        if (rst) begin
            poll_cnt <= '0;
            error    <= 1'b0;
        end else if (state == IDLE && go) begin
            poll_cnt <= '0;
            error    <= 1'b0;
        end else begin
            if (state == POLL_RD && xfer_ok)
                poll_cnt <= poll_cnt + 1'b1;
            if (state == POLL_WAIT && av.readdatavalid && !stat_done && poll_expired)
                error <= 1'b1;
        end
    end
`else
    assign poll_expired = 1'b0;
    assign error        = 1'b0;
`endif

    // Only bits [1:0] of status and [16:0] of results carry information.
    logic unused_bits;
    assign unused_bits = ^{av.readdata[31:17], TIMEOUT_POLLS[0]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; every bus state holds until the slave stops stalling.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (go) state_nx = CLR_SET;
            CLR_SET:   if (xfer_ok) state_nx = CLR_REL;
            CLR_REL:   if (xfer_ok) state_nx = PIX_FETCH;
            PIX_FETCH: state_nx = PIX_LOAD;
            PIX_LOAD:  state_nx = PIX_WR;
            PIX_WR:    if (xfer_ok) state_nx = (cnt == PIX_LAST) ? WGT_FETCH : PIX_FETCH;
            WGT_FETCH: state_nx = WGT_LOAD;
            WGT_LOAD:  state_nx = WGT_WR;
            WGT_WR:    if (xfer_ok) state_nx = (cnt == WGT_LAST) ? START : WGT_FETCH;
            START:     if (xfer_ok) state_nx = POLL_RD;
            POLL_RD:   if (xfer_ok) state_nx = POLL_WAIT;
            POLL_WAIT: if (av.readdatavalid) begin
                           if (stat_done)         state_nx = RES_RD;
                           else if (poll_expired) state_nx = STOP;
                           else                   state_nx = POLL_RD;
                       end
            RES_RD:    if (xfer_ok) state_nx = RES_WAIT;
            RES_WAIT:  if (av.readdatavalid) state_nx = (cnt == RES_LAST) ? STOP : RES_RD;
            STOP:      if (xfer_ok) state_nx = FIN;
            FIN:       state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Bus, source and status outputs decoded from the current state.
    always_comb begin
        av.write     = 1'b0;
        av.read      = 1'b0;
        av.address   = '0;
        av.writedata = '0;
        src_rd       = 1'b0;
        src_addr     = '0;
        case (state)
            CLR_SET:   begin av.write = 1'b1; av.address = CTRL_A; av.writedata = 32'h1; end
            CLR_REL:   begin av.write = 1'b1; av.address = CTRL_A; av.writedata = 32'h0; end
            PIX_FETCH: begin src_rd = 1'b1; src_addr = cnt; end
            PIX_WR:    begin av.write = 1'b1; av.address = {cnt, 1'b0}; av.writedata = wdata_q; end
            WGT_FETCH: begin src_rd = 1'b1; src_addr = WGT_SRC + cnt; end
            WGT_WR:    begin av.write = 1'b1; av.address = WGT_A + {1'b0, cnt}; av.writedata = wdata_q; end
            START:     begin av.write = 1'b1; av.address = CTRL_A; av.writedata = 32'h8; end
            POLL_RD:   begin av.read = 1'b1; av.address = STAT_A; end
            RES_RD:    begin av.read = 1'b1; av.address = RES_A + {1'b0, cnt}; end
            STOP:      begin av.write = 1'b1; av.address = CTRL_A; av.writedata = 32'h0; end
            default:   ;
        endcase
    end

    assign av.burstcount         = 10'd1;
    assign av.beginbursttransfer = 1'b0;
    assign busy = (state != IDLE) && (state != FIN);
    assign done = (state == FIN);

    // Word counter, source data register, overflow capture and result port.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            wdata_q      <= '0;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
            result_data  <= '0;
            result_idx   <= '0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    cnt      <= '0;
                    overflow <= 1'b0;
                end
                PIX_LOAD, WGT_LOAD: wdata_q <= src_rdata;
                PIX_WR: if (xfer_ok) cnt <= (cnt == PIX_LAST) ? 12'd0 : cnt + 12'd1;
                WGT_WR: if (xfer_ok) cnt <= (cnt == WGT_LAST) ? 12'd0 : cnt + 12'd1;
                POLL_WAIT: if (av.readdatavalid && stat_done) begin
                    overflow <= av.readdata[1];
                    cnt      <= '0;
                end
                RES_WAIT: if (av.readdatavalid) begin
                    result_valid <= 1'b1;
                    result_data  <= av.readdata[16:0];
                    result_idx   <= cnt[3:0];
                    if (cnt != RES_LAST) cnt <= cnt + 12'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
